// File: rtl/melody_sequencer.sv
// Tempo-driven song controller: fetches one ROM entry per note, holds it for dur beats, then a short gap.
// Beat timebase is derived from clock; tempo and loop mode are sampled only at note boundaries.
module melody_sequencer #(
   parameter int BEAT_CYCLES = 12500000,
   parameter int GAP_CYCLES  = 1250000,
   parameter int SONG_LEN    = 32,
   parameter int ADDR_W      = 5,
   parameter int NOTE_W      = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              play,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [1:0]        tempo_sel,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [NOTE_W+2:0] rom_data,
   output logic [NOTE_W-1:0] note_code,
   output logic              note_valid,
   output logic              beat_tick,
   output logic              busy,
   output logic              done
);

   localparam int MAX_CYC = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0]     BEAT_L   = CW'(BEAT_CYCLES);
   localparam logic [CW-1:0]     GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(SONG_LEN - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FETCH_A = 3'd1;
   localparam logic [2:0] FETCH_D = 3'd2;
   localparam logic [2:0] PLAY    = 3'd3;
   localparam logic [2:0] GAP     = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   logic [2:0]        state;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     beat_len;
   logic [2:0]        beats_left;
   logic [NOTE_W-1:0] rom_note;
   logic [2:0]        rom_dur;
   logic              beat_end;

   assign rom_note = rom_data[NOTE_W+2:3];
   assign rom_dur  = rom_data[2:0];

   assign beat_end  = (state == PLAY) && (cnt == beat_len - CW'(1));
   assign beat_tick = beat_end;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rom_addr   <= '0;
         note_code  <= '0;
         note_valid <= 1'b0;
         cnt        <= '0;
         beat_len   <= '0;
         beats_left <= '0;
      end else if (stop) begin
         // abort from anywhere; no done pulse
         state      <= IDLE;
         rom_addr   <= '0;
         note_valid <= 1'b0;
         cnt        <= '0;
         beat_len   <= '0;
         beats_left <= '0;
      end else begin
         case (state)
            IDLE: begin
               rom_addr <= '0;
               if (play)
                  state <= FETCH_A;
            end
            FETCH_A: state <= FETCH_D;
            FETCH_D: begin
               if (rom_dur == 3'd0) begin
                  state <= DONE;
               end else begin
                  note_code  <= rom_note;
                  beats_left <= rom_dur;
                  beat_len   <= BEAT_L >> tempo_sel;
                  cnt        <= '0;
                  note_valid <= (rom_note != '0);
                  state      <= PLAY;
               end
            end
            PLAY: begin
               if (beat_end) begin
                  cnt        <= '0;
                  beats_left <= beats_left - 3'd1;
                  if (beats_left == 3'd1) begin
                     note_valid <= 1'b0;
                     state      <= GAP;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (rom_addr != LAST_A) begin
                     rom_addr <= rom_addr + ADDR_W'(1);
                     state    <= FETCH_A;
                  end else if (loop_en) begin
                     rom_addr <= '0;
                     state    <= FETCH_A;
                  end else begin
                     state <= DONE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               rom_addr <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a small synchronous song ROM (beat 8, gap 2, 4 entries).
module tb_melody_sequencer;

   logic       clock;
   logic       reset;
   logic       play;
   logic       stop;
   logic       loop_en;
   logic [1:0] tempo_sel;
   logic [1:0] rom_addr;
   logic [6:0] rom_data;
   logic [3:0] note_code;
   logic       note_valid;
   logic       beat_tick;
   logic       busy;
   logic       done;

   logic [6:0] rom [4];
   int n_tests;
   int n_fail;
   int done_cnt;

   melody_sequencer #(
      .BEAT_CYCLES(8), .GAP_CYCLES(2), .SONG_LEN(4), .ADDR_W(2), .NOTE_W(4)
   ) dut (
      .clock(clock), .reset(reset), .play(play), .stop(stop), .loop_en(loop_en),
      .tempo_sel(tempo_sel), .rom_addr(rom_addr), .rom_data(rom_data),
      .note_code(note_code), .note_valid(note_valid), .beat_tick(beat_tick),
      .busy(busy), .done(done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) rom_data <= rom[rom_addr];

   always @(negedge clock) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
         $error("%s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // counts consecutive negedge samples with note_valid==v, starting at the current sample
   task automatic run(input logic v, output int len, output int ticks, output int code);
      len = 0;
      ticks = 0;
      code = int'(note_code);
      while (note_valid === v && len < 500) begin
         len++;
         if (beat_tick === 1'b1) ticks++;
         @(negedge clock);
      end
   endtask

   task automatic wait_done(output int n, output int nv_hi);
      n = 0;
      nv_hi = 0;
      while (done !== 1'b1 && n < 500) begin
         n++;
         if (note_valid === 1'b1) nv_hi++;
         @(negedge clock);
      end
   endtask

   task automatic start();
      play = 1'b1;
      @(negedge clock);
      play = 1'b0;
   endtask

   task automatic stop_pulse();
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, ticks, code, n, nvh, d0;
      n_tests = 0;
      n_fail = 0;
      done_cnt = 0;
      reset = 1'b1;
      play = 1'b0;
      stop = 1'b0;
      loop_en = 1'b0;
      tempo_sel = 2'd0;
      rom[0] = {4'd3, 3'd2};
      rom[1] = {4'd5, 3'd1};
      rom[2] = {4'd0, 3'd1};
      rom[3] = {4'd7, 3'd1};
      repeat (2) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_note_valid", note_valid, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_note_code", note_code, 0);
      chk("rst_done", done, 0);
      chk("rst_beat_tick", beat_tick, 0);
      reset = 1'b0;
      @(negedge clock);

      // 1: single pass, no loop
      start();
      run(0, len, ticks, code); chk("t1_fetch_low", len, 2);
      run(1, len, ticks, code); chk("t1_n0_len", len, 16); chk("t1_n0_code", code, 3);
      chk("t1_n0_ticks", ticks, 2);
      run(0, len, ticks, code); chk("t1_gap0_low", len, 4);
      run(1, len, ticks, code); chk("t1_n1_len", len, 8); chk("t1_n1_code", code, 5);
      run(0, len, ticks, code); chk("t1_rest_low", len, 16);
      run(1, len, ticks, code); chk("t1_n3_len", len, 8); chk("t1_n3_code", code, 7);
      wait_done(n, nvh); chk("t1_done_delay", n, 2);
      @(negedge clock);
      chk("t1_done_width", done, 0);
      chk("t1_idle_busy", busy, 0);
      chk("t1_idle_addr", rom_addr, 0);
      chk("t1_done_count", done_cnt, 1);

      // 2: looping, then stop
      loop_en = 1'b1;
      d0 = done_cnt;
      start();
      run(0, len, ticks, code);
      run(1, len, ticks, code);
      run(0, len, ticks, code);
      run(1, len, ticks, code);
      run(0, len, ticks, code);
      run(1, len, ticks, code); chk("t2_n3_code", code, 7);
      run(0, len, ticks, code); chk("t2_wrap_low", len, 4);
      chk("t2_wrap_addr", rom_addr, 0);
      chk("t2_wrap_code", note_code, 3);
      chk("t2_wrap_valid", note_valid, 1);
      stop_pulse();
      chk("t2_stop_busy", busy, 0);
      chk("t2_stop_valid", note_valid, 0);
      chk("t2_stop_addr", rom_addr, 0);
      chk("t2_no_done", done_cnt, d0);
      loop_en = 1'b0;

      // 3: end marker at entry 1
      rom[1] = {4'd5, 3'd0};
      d0 = done_cnt;
      start();
      run(0, len, ticks, code);
      run(1, len, ticks, code); chk("t3_n0_len", len, 16);
      wait_done(n, nvh); chk("t3_done_delay", n, 4); chk("t3_no_sound", nvh, 0);
      chk("t3_code_held", note_code, 3);
      @(negedge clock);
      chk("t3_idle_busy", busy, 0);
      chk("t3_done_count", done_cnt, d0 + 1);
      rom[1] = {4'd5, 3'd1};

      // 4: tempo change mid-note applies at next fetch
      start();
      run(0, len, ticks, code);
      tempo_sel = 2'd2;
      run(1, len, ticks, code); chk("t4_n0_len", len, 16); chk("t4_n0_ticks", ticks, 2);
      run(0, len, ticks, code); chk("t4_gap_low", len, 4);
      run(1, len, ticks, code); chk("t4_n1_len", len, 2); chk("t4_n1_ticks", ticks, 1);
      chk("t4_n1_code", code, 5);
      stop_pulse();
      tempo_sel = 2'd0;

      // 5: stop wins over play; play while busy ignored
      play = 1'b1;
      stop = 1'b1;
      @(negedge clock);
      play = 1'b0;
      stop = 1'b0;
      chk("t5_play_stop_busy", busy, 0);
      start();
      run(0, len, ticks, code);
      repeat (5) @(negedge clock);
      start();
      run(1, len, ticks, code); chk("t5_rest_of_note", len, 10);
      chk("t5_addr_in_gap", rom_addr, 0);
      run(0, len, ticks, code);
      chk("t5_next_addr", rom_addr, 1);
      chk("t5_next_code", note_code, 5);
      stop_pulse();

      // 6: async reset between edges
      start();
      run(0, len, ticks, code);
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_valid", note_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_code", note_code, 0);
      chk("t6_rst_addr", rom_addr, 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      start();
      run(0, len, ticks, code); chk("t6_fetch_low", len, 2);
      chk("t6_restart_addr", rom_addr, 0);
      run(1, len, ticks, code); chk("t6_n0_len", len, 16); chk("t6_n0_code", code, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
